// File: rtl/gate_lane_arbiter.sv
// Round-robin arbiter sharing one gate controller between N_LANES entry lanes.
// Optional macro GATE_ARB_PRIO0_EN makes lane 0 a fixed-priority emergency lane.
module gate_lane_arbiter #(
  parameter int unsigned N_LANES = 2,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [N_LANES-1:0] lane_car_i,
  input  logic [N_LANES-1:0] lane_pay_ok_i,
  input  logic               clear_i,
  input  logic               gate_open_i,
  input  logic               gate_close_i,
  output logic               gate_car_o,
  output logic               gate_pay_ok_o,
  output logic [N_LANES-1:0] grant_o,
  output logic [N_LANES-1:0] pending_o,
  output logic [N_LANES-1:0] done_o,
  output logic               abort_o,
  output logic               busy_o,
  output logic [7:0]         abort_cnt_o
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned LW = $clog2(N_LANES);
`ifdef GATE_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_OPEN,
    S_WAIT_CLOSE,
    S_DONE,
    S_ABORT
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [LW-1:0]     last;
  logic [TW-1:0]     cnt;
  logic [LW-1:0]     win_c;
  logic              found_c;
  logic              prio_hit_c;
  logic              issue_c;
  logic [N_LANES-1:0] win_oh_c;
  logic [N_LANES-1:0] req_c;
  int unsigned       idx;

  assign req_c = lane_car_i & lane_pay_ok_i;

  // Winner: first pending lane after the last grant, wrapping; lane 0 may pre-empt.
  always_comb begin
    win_c      = '0;
    found_c    = 1'b0;
    prio_hit_c = 1'b0;
    idx        = 0;
    for (int unsigned k = 1; k <= N_LANES; k++) begin
      idx = 32'(last) + k;
      if (idx >= N_LANES) idx = idx - N_LANES;
      if (!found_c && pending_o[LW'(idx)] && !(PRIO0 && idx == 0)) begin
        win_c   = LW'(idx);
        found_c = 1'b1;
      end
    end
    if (PRIO0 && pending_o[0]) begin
      win_c      = '0;
      found_c    = 1'b1;
      prio_hit_c = 1'b1;
    end
  end

  assign issue_c  = (state == S_IDLE) && found_c;
  assign win_oh_c = N_LANES'(1) << win_c;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:       if (found_c) state_n = S_ISSUE;
      S_ISSUE:      state_n = S_WAIT_OPEN;
      S_WAIT_OPEN: begin
        if (gate_open_i) state_n = S_WAIT_CLOSE;
        else if (clear_i && cnt == TW'(TIMEOUT - 1)) state_n = S_ABORT;
      end
      S_WAIT_CLOSE: if (gate_close_i) state_n = S_DONE;
      S_DONE:       state_n = S_IDLE;
      S_ABORT:      state_n = S_IDLE;
      default:      state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) state <= S_IDLE;
    else           state <= state_n;
  end

  // Registered outputs, pending latch, rr pointer and timeout counter.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      last          <= LW'(N_LANES - 1);
      cnt           <= '0;
      pending_o     <= '0;
      grant_o       <= '0;
      done_o        <= '0;
      gate_car_o    <= 1'b0;
      gate_pay_ok_o <= 1'b0;
      abort_o       <= 1'b0;
      busy_o        <= 1'b0;
      abort_cnt_o   <= '0;
    end else begin
      // A fresh request on the lane being issued survives the clear.
      pending_o <= (pending_o & ~(issue_c ? win_oh_c : '0)) | req_c;

      if (issue_c) begin
        grant_o <= win_oh_c;
        if (!prio_hit_c) last <= win_c;
      end else if (state_n == S_IDLE) begin
        grant_o <= '0;
      end

      if (state == S_WAIT_OPEN && state_n == S_WAIT_OPEN) begin
        if (clear_i) cnt <= cnt + TW'(1);
      end else begin
        cnt <= '0;
      end

      gate_car_o    <= issue_c;
      gate_pay_ok_o <= issue_c;
      done_o        <= (state_n == S_DONE) ? grant_o : '0;
      abort_o       <= (state_n == S_ABORT);
      busy_o        <= (state_n != S_IDLE);
      if (state_n == S_ABORT && abort_cnt_o != 8'hFF) abort_cnt_o <= abort_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_gate_lane_arbiter.sv
// Self-checking bench for gate_lane_arbiter: vector table, directed sequences,
// and randomized traffic checked against a behavioural service model.
module tb_gate_lane_arbiter;

  localparam int unsigned N = 3;
  localparam int unsigned T = 8;
`ifdef GATE_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] car = '0;
  logic [N-1:0] pay = '0;
  logic         clear = 1'b0;
  logic         opn = 1'b0;
  logic         cls = 1'b0;
  logic         gate_car_o, gate_pay_ok_o, abort_o, busy_o;
  logic [N-1:0] grant_o, pending_o, done_o;
  logic [7:0]   abort_cnt_o;

  int vec_cnt = 0;
  int miscompares = 0;

  gate_lane_arbiter #(.N_LANES(N), .TIMEOUT(T)) dut (
    .clk_i(clk), .reset_ni(rst_n), .lane_car_i(car), .lane_pay_ok_i(pay),
    .clear_i(clear), .gate_open_i(opn), .gate_close_i(cls),
    .gate_car_o(gate_car_o), .gate_pay_ok_o(gate_pay_ok_o), .grant_o(grant_o),
    .pending_o(pending_o), .done_o(done_o), .abort_o(abort_o), .busy_o(busy_o),
    .abort_cnt_o(abort_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Service model: phase 0 idle, 1 issue, 2 wait open, 3 wait close, 4 done, 5 abort.
  logic [N-1:0] m_pend;
  int m_last, m_phase, m_lane, m_clears, m_aborts;

  function automatic bit bitof(logic [N-1:0] v, int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic int oh2idx(logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < int'(N); i++) if (bitof(v, i)) r = i;
    return r;
  endfunction

  task automatic model_step();
    logic [N-1:0] req, oh;
    int w, l;
    bit pw;
    req = car & pay;
    if (!rst_n) begin
      m_pend = '0; m_last = int'(N) - 1; m_phase = 0; m_lane = 0; m_clears = 0; m_aborts = 0;
      return;
    end
    oh = '0;
    case (m_phase)
      0: begin
        w = -1; pw = 1'b0;
        if (PRIO && bitof(m_pend, 0)) begin w = 0; pw = 1'b1; end
        else begin
          for (int k = 1; k <= int'(N); k++) begin
            l = (m_last + k) % int'(N);
            if (w < 0 && bitof(m_pend, l) && !(PRIO && l == 0)) w = l;
          end
        end
        if (w >= 0) begin
          m_phase = 1; m_lane = w; oh = N'(1) << w;
          if (!pw) m_last = w;
        end
      end
      1: begin m_phase = 2; m_clears = 0; end
      2: begin
        if (opn) m_phase = 3;
        else if (clear) begin
          m_clears++;
          if (m_clears == int'(T)) begin m_phase = 5; m_aborts++; end
        end
      end
      3: if (cls) m_phase = 4;
      default: m_phase = 0;
    endcase
    m_pend = (m_pend & ~oh) | req;
  endtask

  task automatic check_model();
    logic [N-1:0] eg, ed;
    logic ec, ea, eb;
    logic [7:0] ecnt;
    ec = (m_phase == 1);
    eg = (m_phase != 0) ? (N'(1) << m_lane) : '0;
    ed = (m_phase == 4) ? (N'(1) << m_lane) : '0;
    ea = (m_phase == 5);
    eb = (m_phase != 0);
    ecnt = (m_aborts > 255) ? 8'd255 : 8'(m_aborts);
    vec_cnt++;
    if (gate_car_o !== ec || gate_pay_ok_o !== ec || grant_o !== eg || pending_o !== m_pend ||
        done_o !== ed || abort_o !== ea || busy_o !== eb || abort_cnt_o !== ecnt) begin
      miscompares++;
      $display("FAIL model t=%0t got car=%b pay=%b grant=%b pend=%b done=%b abort=%b busy=%b cnt=%0d, expected car=%b grant=%b pend=%b done=%b abort=%b busy=%b cnt=%0d",
               $time, gate_car_o, gate_pay_ok_o, grant_o, pending_o, done_o, abort_o, busy_o,
               abort_cnt_o, ec, eg, m_pend, ed, ea, eb, ecnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; car = '0; pay = '0; clear = 1'b0; opn = 1'b0; cls = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_issue(string name);
    int n;
    n = 0;
    while (gate_car_o !== 1'b1 && n < 64) begin tick(); n++; end
    chk(name, 32'(n < 64), 32'd1);
  endtask

  // Completes one service: open two cycles after issue, close three after open.
  task automatic serve(input logic [N-1:0] inject, output int lane, output logic [N-1:0] pend_at);
    wait_issue("serve_issue");
    lane = oh2idx(grant_o);
    pend_at = pending_o;
    if (inject != '0) begin
      car = inject; pay = inject; tick(); car = '0; pay = '0;
    end else tick();
    tick();
    opn = 1'b1; tick(); opn = 1'b0;
    tick(); tick();
    cls = 1'b1; tick(); cls = 1'b0;
    chk("done_lane", 32'(done_o), 32'(grant_o));
    tick();
  endtask

  typedef struct {
    logic [N-1:0] car, pay;
    logic clr, opn, cls;
    logic e_car;
    logic [N-1:0] e_grant, e_done, e_pend;
    logic e_busy;
  } vec_t;

  function automatic vec_t mk(logic [N-1:0] c, logic cl, logic o, logic cs,
                              logic ec, logic [N-1:0] eg, logic [N-1:0] ed,
                              logic [N-1:0] ep, logic eb);
    vec_t v;
    v.car = c; v.pay = c; v.clr = cl; v.opn = o; v.cls = cs;
    v.e_car = ec; v.e_grant = eg; v.e_done = ed; v.e_pend = ep; v.e_busy = eb;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    int lane, n, pulses;
    int order[4];
    logic [N-1:0] pa[4];
    bit seen;

    // Single lane-1 service; gate pulses in IDLE must be ignored.
    tbl[0]  = mk(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b010, 1'b0);
    tbl[1]  = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 3'b000, 1'b1);
    tbl[2]  = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1);
    tbl[3]  = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1);
    tbl[4]  = mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1);
    tbl[5]  = mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1);
    tbl[6]  = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1);
    tbl[7]  = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1);
    tbl[8]  = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1);
    tbl[9]  = mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 3'b010, 3'b000, 1'b1);
    tbl[10] = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    tbl[11] = mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    tbl[12] = mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);
    tbl[13] = mk(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0);

    do_reset();
    chk("reset_outputs", 32'({gate_car_o, grant_o, pending_o, done_o, abort_o, busy_o, abort_cnt_o}), 32'd0);

    for (int i = 0; i < 14; i++) begin
      car = tbl[i].car; pay = tbl[i].pay; clear = tbl[i].clr; opn = tbl[i].opn; cls = tbl[i].cls;
      tick();
      vec_cnt++;
      if (gate_car_o !== tbl[i].e_car || grant_o !== tbl[i].e_grant || done_o !== tbl[i].e_done ||
          pending_o !== tbl[i].e_pend || busy_o !== tbl[i].e_busy) begin
        miscompares++;
        $display("FAIL table[%0d] got car=%b grant=%b done=%b pend=%b busy=%b, expected car=%b grant=%b done=%b pend=%b busy=%b",
                 i, gate_car_o, grant_o, done_o, pending_o, busy_o, tbl[i].e_car, tbl[i].e_grant,
                 tbl[i].e_done, tbl[i].e_pend, tbl[i].e_busy);
      end
    end
    car = '0; pay = '0; clear = 1'b0; opn = 1'b0; cls = 1'b0;

    // Contention: lanes 0 and 1 together after reset.
    do_reset();
    car = 3'b011; pay = 3'b011; tick(); car = '0; pay = '0;
    chk("contend_pend0", 32'(pending_o), 32'b011);
    serve('0, order[0], pa[0]);
    serve('0, order[1], pa[1]);
    chk("contend_first", 32'(order[0]), 32'd0);
    chk("contend_second", 32'(order[1]), 32'd1);
    chk("contend_pend1", 32'(pa[0]), 32'b010);
    chk("contend_pend2", 32'(pa[1]), 32'b000);

    // Fairness with lanes 0 and 1 held continuously.
    do_reset();
    car = 3'b011; pay = 3'b011;
    for (int i = 0; i < 4; i++) serve('0, order[i], pa[i]);
    for (int i = 0; i < 4; i++) chk("fair_order", 32'(order[i]), 32'(i % 2));

    // Lane 1 in service while lanes 0 and 2 arrive.
    do_reset();
    car = 3'b010; pay = 3'b010; tick(); car = '0; pay = '0;
    serve(3'b101, order[0], pa[0]);
    serve('0, order[1], pa[1]);
    serve('0, order[2], pa[2]);
    chk("prio_first", 32'(order[0]), 32'd1);
    chk("prio_second", 32'(order[1]), PRIO ? 32'd0 : 32'd2);
    chk("prio_third", 32'(order[2]), PRIO ? 32'd2 : 32'd0);

    // Timeout with clear held high.
    do_reset();
    clear = 1'b1;
    car = 3'b100; pay = 3'b100; tick(); car = '0; pay = '0;
    wait_issue("to_issue");
    n = 0;
    while (abort_o !== 1'b1 && n < 200) begin tick(); n++; end
    chk("abort_latency", 32'(n), 32'(T + 1));
    chk("abort_cnt_1", 32'(abort_cnt_o), 32'd1);
    tick();
    chk("no_requeue", 32'(pending_o), 32'd0);
    tick(); tick();
    chk("no_reissue", 32'({gate_car_o, busy_o}), 32'd0);

    // Clear held low: the gate may wait indefinitely.
    clear = 1'b0;
    car = 3'b100; pay = 3'b100; tick(); car = '0; pay = '0;
    wait_issue("hold_issue");
    seen = 1'b0;
    repeat (100) begin tick(); if (abort_o === 1'b1) seen = 1'b1; end
    chk("hold_no_abort", 32'(seen), 32'd0);
    chk("hold_busy", 32'(busy_o), 32'd1);
    clear = 1'b1;
    n = 0;
    while (abort_o !== 1'b1 && n < 200) begin tick(); n++; end
    chk("abort_cnt_2", 32'(abort_cnt_o), 32'd2);

    // Saturation of the abort counter.
    car = 3'b010; pay = 3'b010;
    pulses = 0; n = 0;
    while (pulses < 300 && n < 20000) begin tick(); n++; if (abort_o === 1'b1) pulses++; end
    car = '0; pay = '0;
    chk("abort_pulses", 32'(pulses), 32'd300);
    chk("abort_sat", 32'(abort_cnt_o), 32'd255);

    // Reset while waiting for the close pulse.
    do_reset();
    car = 3'b001; pay = 3'b001; tick(); car = '0; pay = '0;
    wait_issue("rst_issue");
    tick();
    opn = 1'b1; tick(); opn = 1'b0;
    tick();
    chk("rst_pre_busy", 32'(busy_o), 32'd1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_outputs", 32'({gate_car_o, gate_pay_ok_o, grant_o, pending_o, done_o, abort_o, busy_o, abort_cnt_o}), 32'd0);
    cls = 1'b1; tick(); cls = 1'b0;
    seen = 1'b0;
    repeat (5) begin tick(); if (done_o !== '0) seen = 1'b1; end
    chk("rst_no_done", 32'(seen), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < int'(N); b++) begin
        car[b] = ($urandom_range(3) == 0);
        pay[b] = ($urandom_range(3) != 0);
      end
      clear = 1'($urandom_range(1));
      opn = ($urandom_range(9) == 0);
      cls = ($urandom_range(5) == 0);
      rst_n = ($urandom_range(499) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
